pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects load-use hazards at ID,
//  squashes younger stages on an EX redirect, freezes the pipe on data-memory wait states, and drops
//  stale instruction-fetch responses after a redirect. Drives stall_signal/flushing_inst into ID
//  and the write-enables of every pipeline register.
// PARAMETERS
//  MAX_IFETCH  2   max outstanding imem requests tracked (counter width = $clog2(MAX_IFETCH+1))
//  PERF_W      32  width of performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk            in   1  clock
//  rst            in   1  reset, asynchronous, active-high
//  id_valid       in   1  valid instruction in ID
//  id_rs1_s       in   5  ID source reg 1
//  id_rs2_s       in   5  ID source reg 2
//  id_uses_rs1    in   1  ID instruction reads rs1
//  id_uses_rs2    in   1  ID instruction reads rs2
//  ex_valid       in   1  valid instruction in EX
//  ex_is_load     in   1  EX instruction is a load
//  ex_rd_s        in   5  EX destination reg
//  ex_redirect    in   1  EX resolved taken branch/jal/jalr; PC loads target this cycle
//  imem_req       in   1  fetch request issued this cycle
//  imem_resp      in   1  fetch response returned this cycle (in order)
//  dmem_req       in   1  MEM stage issues load/store this cycle
//  dmem_resp      in   1  data memory response this cycle
//  pc_we          out  1  PC register write enable
//  if_id_we       out  1  IF/ID write enable
//  if_id_flush    out  1  IF/ID loads invalid bubble
//  stall_signal   out  1  ID emits bubble into ID/EX (load-use)
//  flushing_inst  out  1  ID emits bubble into ID/EX (redirect)
//  id_ex_we       out  1  ID/EX write enable
//  ex_mem_we      out  1  EX/MEM write enable
//  mem_wb_we      out  1  MEM/WB write enable
//  imem_drop      out  1  discard current imem_resp
//  ifetch_full    out  1  outstanding fetches == MAX_IFETCH; fetch unit must not issue
// BEHAVIOUR
//  - Reset: state=RUN, ifetch_cnt=0, drop_cnt=0; outputs: all *_we=1, all flush/stall/drop=0.
//  - FSM {RUN, DMEM_WAIT}. RUN->DMEM_WAIT: dmem_req & !dmem_resp. DMEM_WAIT->RUN: dmem_resp.
//  - DMEM_WAIT (and RUN cycle with dmem_req & !dmem_resp): all *_we=0; stall/flush outputs 0;
//    EX-side hazards re-evaluated after exit. Highest priority.
//  - Redirect (ex_redirect, pipe not frozen): pc_we=1, if_id_flush=1, flushing_inst=1,
//    id_ex_we=1, ex_mem_we=1. Beats load-use in the same cycle (ID instr squashed).
//  - Load-use: ex_valid & ex_is_load & ex_rd_s!=0 & id_valid & ((id_uses_rs1 & rs1==rd) |
//    (id_uses_rs2 & rs2==rd)) -> pc_we=0, if_id_we=0, stall_signal=1; exactly 1 cycle
//    (load leaves EX next cycle; MEM->EX forwarding covers rest). Combinational, 0 latency.
//  - ifetch_cnt: +imem_req -imem_resp each cycle (both = hold). imem_req at full -> assertion fail.
//  - drop_cnt: on redirect loads ifetch_cnt_next minus that cycle's dropped resp; otherwise
//    decrements on imem_resp while nonzero. imem_drop = imem_resp & drop_cnt!=0. Counts in
//    any FSM state, including DMEM_WAIT. Back-to-back redirects reload (no accumulation).
//  - imem_drop also forces if_id_we=0 for that response.
//  - rst mid-operation: immediate return to reset values; in-flight responses not tracked.
// CONFIGURATION
//  HAZARD_PERF_EN defined: extra outputs perf_loaduse_cnt, perf_flush_cnt, perf_dmem_stall_cnt
//   (PERF_W, wrapping, reset 0), incremented on load-use cycles, redirects, DMEM_WAIT-freeze cycles.
//  Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  rv32i_types: hazard_state_t enum {RUN, DMEM_WAIT}; hazard_ctrl_t struct bundling the *_we/flush
//  outputs. Sub-module hazard_fetch_tracker: ifetch_cnt, drop_cnt, imem_drop, ifetch_full.
// TESTING
//  1 Load x5 in EX, ID add uses rs2=x5 -> stall_signal=1, pc_we=0 for exactly 1 cycle.
//  2 Same with ex_rd_s=0, or id_uses_rs2=0 -> no stall.
//  3 2 fetches outstanding, ex_redirect -> flushing_inst=1, if_id_flush=1; next 2 imem_resp
//    have imem_drop=1; 3rd resp accepted.
//  4 dmem_req, dmem_resp after 3 cycles -> all *_we=0 for 3 cycles; RUN on resp cycle.
//  5 ex_redirect + load-use same cycle -> flush only, stall_signal=0.
//  6 rst asserted in DMEM_WAIT with drop_cnt=1 -> state RUN, counters 0 asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
// Contents:
//   REG_W           architectural register index width
//   hazard_state_t  RUN / DMEM_WAIT sequencer states
//   hazard_ctrl_t   bundle of pipeline-register enables and bubble/flush controls
//   load_use_hit()  RAW check of the ID sources against a load sitting in EX
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN       = 1'b0,
    DMEM_WAIT = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic stall_signal;
    logic flushing_inst;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
  } hazard_ctrl_t;

  // Free-running pipe: every register advances, nothing squashed.
  localparam hazard_ctrl_t CTRL_RUN = '{
    pc_we:         1'b1,
    if_id_we:      1'b1,
    if_id_flush:   1'b0,
    stall_signal:  1'b0,
    flushing_inst: 1'b0,
    id_ex_we:      1'b1,
    ex_mem_we:     1'b1,
    mem_wb_we:     1'b1
  };

  // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
  function automatic logic load_use_hit(
    input logic             ex_valid,
    input logic             ex_is_load,
    input logic [REG_W-1:0] ex_rd,
    input logic             id_valid,
    input logic             uses_rs1,
    input logic             uses_rs2,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    return ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Modports:
//   master  pipeline side: drives ID/EX/imem/dmem status, receives enables/flushes
//   slave   hazard controller side
// Signals:
//   id_valid, id_rs1_s, id_rs2_s, id_uses_rs1, id_uses_rs2   ID stage operands
//   ex_valid, ex_is_load, ex_rd_s, ex_redirect                EX stage status
//   imem_req, imem_resp, dmem_req, dmem_resp                  memory handshakes
//   pc_we, if_id_we, if_id_flush, stall_signal, flushing_inst,
//   id_ex_we, ex_mem_we, mem_wb_we, imem_drop, ifetch_full    controller outputs
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1_s;
  logic [REG_W-1:0] id_rs2_s;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd_s;
  logic             ex_redirect;
  logic             imem_req;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             stall_signal;
  logic             flushing_inst;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             imem_drop;
  logic             ifetch_full;

  modport master (
    output id_valid, id_rs1_s, id_rs2_s, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_is_load, ex_rd_s, ex_redirect,
           imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_we, if_id_we, if_id_flush, stall_signal, flushing_inst,
           id_ex_we, ex_mem_we, mem_wb_we, imem_drop, ifetch_full
  );

  modport slave (
    input  id_valid, id_rs1_s, id_rs2_s, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_is_load, ex_rd_s, ex_redirect,
           imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_we, if_id_we, if_id_flush, stall_signal, flushing_inst,
           id_ex_we, ex_mem_we, mem_wb_we, imem_drop, ifetch_full
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fetch_tracker.sv
// rtl/pipeline_hazard_ctrl_fetch_tracker.sv - outstanding-fetch and stale-response tracker
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   imem_req     fetch issued this cycle
//   imem_resp    fetch response returned this cycle (in order)
//   redirect     PC is taking a redirect this cycle
//   imem_drop    current response belongs to the pre-redirect path
//   ifetch_full  MAX_IFETCH fetches outstanding
module pipeline_hazard_ctrl_fetch_tracker #(
  parameter int MAX_IFETCH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic imem_req,
  input  logic imem_resp,
  input  logic redirect,
  output logic imem_drop,
  output logic ifetch_full
);

  localparam int CW = $clog2(MAX_IFETCH + 1);

  logic [CW-1:0] ifetch_cnt;
  logic [CW-1:0] ifetch_cnt_next;
  logic [CW-1:0] drop_cnt;

  always_comb begin
    ifetch_cnt_next = ifetch_cnt;
    if (imem_req && !imem_resp) begin
      ifetch_cnt_next = ifetch_cnt + CW'(1);
    end else if (!imem_req && imem_resp) begin
      ifetch_cnt_next = ifetch_cnt - CW'(1);
    end
  end

  assign ifetch_full = (ifetch_cnt == CW'(MAX_IFETCH));
  assign imem_drop   = imem_resp && (drop_cnt != '0);

  // On a redirect every fetch still in flight after this cycle (including one
  // issued this cycle from the old PC) is stale. ifetch_cnt_next already nets
  // out this cycle's response, so reloading from it never double-counts, and a
  // second redirect simply overwrites the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifetch_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      ifetch_cnt <= ifetch_cnt_next;
      if (redirect) begin
        drop_cnt <= ifetch_cnt_next;
      end else if (imem_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  a_no_fetch_when_full: assert property (
    @(posedge clk) disable iff (rst) !(imem_req && ifetch_full)
  );

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
// Optional feature macro: HAZARD_PERF_EN (performance counters).
// Ports:
//   clk                  clock
//   rst                  asynchronous active-high reset
//   bus                  pipeline_hazard_ctrl_if.slave: ID/EX status, imem/dmem
//                        handshakes in; register enables, bubbles, imem_drop,
//                        ifetch_full out
//   perf_loaduse_cnt     load-use stall cycles      (HAZARD_PERF_EN only)
//   perf_flush_cnt       redirects taken            (HAZARD_PERF_EN only)
//   perf_dmem_stall_cnt  data-memory freeze cycles  (HAZARD_PERF_EN only)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MAX_IFETCH = 2
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_hazard_ctrl_if.slave    bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]        perf_loaduse_cnt,
  output logic [PERF_W-1:0]        perf_flush_cnt,
  output logic [PERF_W-1:0]        perf_dmem_stall_cnt
`endif
);

  hazard_state_t state;
  hazard_ctrl_t  ctrl;
  logic          frozen;
  logic          redirect_take;
  logic          load_use;
  logic          imem_drop;
  logic          ifetch_full;

  // The response cycle itself is not frozen: MEM/WB captures the returning data
  // and the rest of the pipe advances with it.
  assign frozen        = ((state == DMEM_WAIT) || bus.dmem_req) && !bus.dmem_resp;
  assign redirect_take = bus.ex_redirect && !frozen;
  assign load_use      = load_use_hit(bus.ex_valid, bus.ex_is_load, bus.ex_rd_s,
                                      bus.id_valid, bus.id_uses_rs1, bus.id_uses_rs2,
                                      bus.id_rs1_s, bus.id_rs2_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:       if (bus.dmem_req && !bus.dmem_resp) state <= DMEM_WAIT;
        DMEM_WAIT: if (bus.dmem_resp)                  state <= RUN;
      endcase
    end
  end

  // Priority: memory freeze, then redirect (squashes the ID instruction, so a
  // simultaneous load-use is moot), then load-use bubble.
  always_comb begin
    ctrl = CTRL_RUN;
    if (frozen) begin
      ctrl = '0;
    end else if (redirect_take) begin
      ctrl.if_id_flush   = 1'b1;
      ctrl.flushing_inst = 1'b1;
    end else if (load_use) begin
      ctrl.pc_we        = 1'b0;
      ctrl.if_id_we     = 1'b0;
      ctrl.stall_signal = 1'b1;
    end
    if (imem_drop) begin
      ctrl.if_id_we = 1'b0;
    end
  end

  pipeline_hazard_ctrl_fetch_tracker #(
    .MAX_IFETCH (MAX_IFETCH)
  ) u_fetch_tracker (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (bus.imem_req),
    .imem_resp   (bus.imem_resp),
    .redirect    (redirect_take),
    .imem_drop   (imem_drop),
    .ifetch_full (ifetch_full)
  );

  assign bus.pc_we         = ctrl.pc_we;
  assign bus.if_id_we      = ctrl.if_id_we;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.stall_signal  = ctrl.stall_signal;
  assign bus.flushing_inst = ctrl.flushing_inst;
  assign bus.id_ex_we      = ctrl.id_ex_we;
  assign bus.ex_mem_we     = ctrl.ex_mem_we;
  assign bus.mem_wb_we     = ctrl.mem_wb_we;
  assign bus.imem_drop     = imem_drop;
  assign bus.ifetch_full   = ifetch_full;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loaduse_cnt    <= '0;
      perf_flush_cnt      <= '0;
      perf_dmem_stall_cnt <= '0;
    end else begin
      if (ctrl.stall_signal)  perf_loaduse_cnt    <= perf_loaduse_cnt + PERF_W'(1);
      if (ctrl.flushing_inst) perf_flush_cnt      <= perf_flush_cnt + PERF_W'(1);
      if (frozen)             perf_dmem_stall_cnt <= perf_dmem_stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard testbench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  // Output vector bit order:
  // [9]pc_we [8]if_id_we [7]if_id_flush [6]stall_signal [5]flushing_inst
  // [4]id_ex_we [3]ex_mem_we [2]mem_wb_we [1]imem_drop [0]ifetch_full
  localparam logic [9:0] RUN_OK = 10'b11_0_0_0_111_0_0;
  localparam logic [9:0] STALL  = 10'b00_0_1_0_111_0_0;
  localparam logic [9:0] REDIR  = 10'b11_1_0_1_111_0_0;
  localparam logic [9:0] FROZEN = 10'b00_0_0_0_000_0_0;
  localparam logic [9:0] IFID   = 10'b01_0_0_0_000_0_0;
  localparam logic [9:0] DROP   = 10'b00_0_0_0_000_1_0;
  localparam logic [9:0] FULL   = 10'b00_0_0_0_000_0_1;
  localparam logic [9:0] RESP_DROPPED = (RUN_OK & ~IFID) | DROP;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_fl, perf_ds;
`endif

  pipeline_hazard_ctrl #(
    .MAX_IFETCH (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus)
`ifdef HAZARD_PERF_EN
    ,
    .perf_loaduse_cnt    (perf_lu),
    .perf_flush_cnt      (perf_fl),
    .perf_dmem_stall_cnt (perf_ds)
`endif
  );

  logic [9:0] obs;
  assign obs = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.stall_signal,
                bus.flushing_inst, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
                bus.imem_drop, bus.ifetch_full};

  sb_item_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      check_eq(it.tag, {22'd0, obs}, {22'd0, it.exp});
    end
  end

  task automatic idle();
    bus.id_valid    = 1'b0;
    bus.id_rs1_s    = 5'd0;
    bus.id_rs2_s    = 5'd0;
    bus.id_uses_rs1 = 1'b0;
    bus.id_uses_rs2 = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.ex_rd_s     = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.imem_req    = 1'b0;
    bus.imem_resp   = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_resp   = 1'b0;
  endtask

  task automatic load_use_setup(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2);
    bus.ex_valid    = 1'b1;
    bus.ex_is_load  = 1'b1;
    bus.ex_rd_s     = rd;
    bus.id_valid    = 1'b1;
    bus.id_rs1_s    = rs1;
    bus.id_rs2_s    = rs2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
  endtask

  // Inputs are already applied; queue the expectation, let the monitor compare
  // at the falling edge, then advance one clock.
  task automatic cyc(input string tag, input logic [9:0] exp);
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", RUN_OK);
    rst = 1'b0;

    // Load-use detection
    idle(); load_use_setup(5'd5, 5'd1, 5'd5, 1'b1, 1'b1); cyc("t1_lu_rs2", STALL);
    idle(); bus.id_valid = 1'b1; bus.id_rs2_s = 5'd5; bus.id_uses_rs2 = 1'b1;
    cyc("t1_lu_release", RUN_OK);
    idle(); load_use_setup(5'd7, 5'd7, 5'd2, 1'b1, 1'b0); cyc("t1_lu_rs1", STALL);
    idle(); load_use_setup(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); cyc("t2_rd_x0", RUN_OK);
    idle(); load_use_setup(5'd5, 5'd1, 5'd5, 1'b1, 1'b0); cyc("t2_no_rs2_use", RUN_OK);
    idle(); load_use_setup(5'd5, 5'd6, 5'd4, 1'b1, 1'b1); cyc("t2_reg_mismatch", RUN_OK);
    idle(); load_use_setup(5'd5, 5'd5, 5'd5, 1'b1, 1'b1); bus.ex_is_load = 1'b0;
    cyc("t2_not_load", RUN_OK);
    idle(); load_use_setup(5'd5, 5'd5, 5'd5, 1'b1, 1'b1); bus.id_valid = 1'b0;
    cyc("t2_id_invalid", RUN_OK);

    // Redirect with two fetches in flight
    idle(); bus.imem_req = 1'b1; cyc("t3_req0", RUN_OK);
    idle(); bus.imem_req = 1'b1; cyc("t3_req1", RUN_OK);
    idle(); bus.ex_redirect = 1'b1; cyc("t3_redirect", REDIR | FULL);
    idle(); bus.imem_resp = 1'b1; cyc("t3_drop0", RESP_DROPPED | FULL);
    idle(); bus.imem_resp = 1'b1; cyc("t3_drop1", RESP_DROPPED);
    idle(); bus.imem_req = 1'b1; cyc("t3_req2", RUN_OK);
    idle(); bus.imem_resp = 1'b1; cyc("t3_accept", RUN_OK);

    // Data-memory wait: three frozen cycles, hazards ignored while frozen
    idle(); bus.dmem_req = 1'b1; cyc("t4_freeze0", FROZEN);
    idle(); load_use_setup(5'd3, 5'd3, 5'd0, 1'b1, 1'b0); bus.ex_redirect = 1'b1;
    cyc("t4_freeze1", FROZEN);
    idle(); cyc("t4_freeze2", FROZEN);
    idle(); bus.dmem_resp = 1'b1; cyc("t4_resp", RUN_OK);
    idle(); cyc("t4_after", RUN_OK);

    // Redirect beats load-use
    idle(); load_use_setup(5'd9, 5'd9, 5'd9, 1'b1, 1'b1); bus.ex_redirect = 1'b1;
    cyc("t5_redir_over_lu", REDIR);

    // Back-to-back redirects reload the drop count
    idle(); bus.imem_req = 1'b1; cyc("b2b_req0", RUN_OK);
    idle(); bus.ex_redirect = 1'b1; cyc("b2b_redir0", REDIR);
    idle(); bus.ex_redirect = 1'b1; bus.imem_req = 1'b1; cyc("b2b_redir1", REDIR);
    idle(); bus.imem_resp = 1'b1; cyc("b2b_drop0", RESP_DROPPED | FULL);
    idle(); bus.imem_resp = 1'b1; bus.imem_req = 1'b1; cyc("b2b_drop1", RESP_DROPPED);
    idle(); bus.imem_resp = 1'b1; cyc("b2b_accept", RUN_OK);

    // Asynchronous reset while in DMEM_WAIT with a pending drop
    idle(); bus.imem_req = 1'b1; cyc("t6_req", RUN_OK);
    idle(); bus.ex_redirect = 1'b1; cyc("t6_redir", REDIR);
    idle(); bus.dmem_req = 1'b1; cyc("t6_enter_wait", FROZEN);
    idle(); bus.imem_resp = 1'b1;
    sb.push_back('{"t6_wait_drop", FROZEN | DROP});
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_eq("t6_async_rst", {22'd0, obs}, {22'd0, RUN_OK});
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(); bus.imem_resp = 1'b1; bus.imem_req = 1'b1; cyc("t6_post_rst", RUN_OK);
    idle(); cyc("t6_idle", RUN_OK);

    @(negedge clk);
    #1 check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
